// File: rtl/bcd_counter_7seg_multi.sv
// N-digit BCD up/down counter with prescaled tick, clear/load, wrap pulse and registered 7-segment outputs.
// Optional define BLANK_LEADING_ZERO_EN blanks leading zero digits above digit 0.
module bcd_counter_7seg_multi #(
  parameter int DIGITS         = 2,
  parameter int MAX_VALUE      = 99,
  parameter int PRESCALE       = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic [8*DIGITS-1:0]   seg_out
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

`ifdef BLANK_LEADING_ZERO_EN
  localparam bit BLANK_LZ = 1'b1;
`else
  localparam bit BLANK_LZ = 1'b0;
`endif

  function automatic logic [W-1:0] to_bcd(input int v);
    int r;
    logic [W-1:0] b;
    r = v;
    b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return b;
  endfunction

  function automatic logic [7:0] seg_enc(input logic [3:0] d, input logic blank);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    if (blank) s = 8'hFF;
    return (SEG_ACTIVE_LOW != 0) ? s : ~s;
  endfunction

  function automatic logic [8*DIGITS-1:0] seg_reset();
    logic [8*DIGITS-1:0] s;
    for (int i = 0; i < DIGITS; i++)
      s[8*i +: 8] = seg_enc(4'd0, BLANK_LZ && (i != 0));
    return s;
  endfunction

  localparam logic [W-1:0]          MAX_BCD = to_bcd(MAX_VALUE);
  localparam logic [8*DIGITS-1:0]   SEG_RST = seg_reset();

  logic [W-1:0]        count_q, count_d, inc_val, dec_val, load_fix;
  logic [PW-1:0]       pre_q, pre_d;
  logic                wrap_q, wrap_d, tick;
  logic [8*DIGITS-1:0] seg_q, seg_d;
  logic [DIGITS-1:0]   carry, borrow, load_bad, zero_hi;

  assign tick      = en && (pre_q == PW'(PRESCALE - 1));
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Per-digit ripple: increment/decrement chains, load validation, leading-zero detect, decode
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] nib;
    assign nib = count_q[4*gi +: 4];
    assign inc_val[4*gi +: 4] = !carry[gi]  ? nib : ((nib == 4'd9) ? 4'd0 : nib + 4'd1);
    assign dec_val[4*gi +: 4] = !borrow[gi] ? nib : ((nib == 4'd0) ? 4'd9 : nib - 4'd1);
    assign load_bad[gi] = (load_val[4*gi +: 4] > 4'd9);
    if (gi < DIGITS - 1) begin : g_chain
      assign carry[gi+1]  = carry[gi]  && (nib == 4'd9);
      assign borrow[gi+1] = borrow[gi] && (nib == 4'd0);
      assign zero_hi[gi]  = (nib == 4'd0) && zero_hi[gi+1];
    end else begin : g_top
      assign zero_hi[gi] = (nib == 4'd0);
    end
    assign seg_d[8*gi +: 8] = seg_enc(nib, BLANK_LZ && (gi != 0) && zero_hi[gi]);
  end

  // With all nibbles valid, BCD ordering matches unsigned vector ordering
  assign load_fix = ((|load_bad) || (load_val > MAX_BCD)) ? MAX_BCD : load_val;

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
      pre_d   = '0;
    end else if (load) begin
      count_d = load_fix;
      pre_d   = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (dir) begin
          if (count_q == MAX_BCD) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = inc_val;
          end
        end else begin
          if (count_q == '0) begin
            count_d = MAX_BCD;
            wrap_d  = 1'b1;
          end else begin
            count_d = dec_val;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= SEG_RST;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign seg_out   = seg_q;

endmodule

// File: tb/tb_bcd_counter_7seg_multi.sv
// Self-checking bench: two instances (default, and PRESCALE=4/MAX_VALUE=57) against a decimal reference model.
module tb_bcd_counter_7seg_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, dir, clr, load;
  logic [7:0]  load_val;
  logic [7:0]  cnt_a, cnt_b;
  logic        wrap_a, wrap_b;
  logic [15:0] seg_a, seg_b;

`ifdef BLANK_LEADING_ZERO_EN
  localparam bit         BLANK = 1'b1;
  localparam logic [7:0] LZ    = 8'hFF;
`else
  localparam bit         BLANK = 1'b0;
  localparam logic [7:0] LZ    = 8'hC0;
`endif
  localparam logic [15:0] SEG_ZERO = {LZ, 8'hC0};

  bcd_counter_7seg_multi dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .count_bcd(cnt_a), .wrap(wrap_a), .seg_out(seg_a));

  bcd_counter_7seg_multi #(.DIGITS(2), .MAX_VALUE(57), .PRESCALE(4), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .count_bcd(cnt_b), .wrap(wrap_b), .seg_out(seg_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain decimal value per instance
  int          mval [2];
  int          mpre [2];
  bit          mwrap[2];
  logic [15:0] mseg [2];
  int          maxv [2] = '{99, 57};
  int          presc[2] = '{1, 4};
  logic [7:0]  seg_tbl[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [15:0] seg_of(input int v);
    logic [15:0] s;
    int pw;
    pw = 1;
    s  = '0;
    for (int d = 0; d < 2; d++) begin
      if (BLANK && d > 0 && v < pw) s[8*d +: 8] = 8'hFF;
      else                          s[8*d +: 8] = seg_tbl[(v / pw) % 10];
      pw = pw * 10;
    end
    return s;
  endfunction

  function automatic logic [7:0] bcd8(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mval[k] = 0; mpre[k] = 0; mwrap[k] = 1'b0; mseg[k] = seg_of(0);
    end
  endtask

  task automatic model_step();
    logic [15:0] ns;
    int v;
    for (int k = 0; k < 2; k++) begin
      ns       = seg_of(mval[k]);
      mwrap[k] = 1'b0;
      if (clr) begin
        mval[k] = 0; mpre[k] = 0;
      end else if (load) begin
        if (load_val[3:0] > 9 || load_val[7:4] > 9) v = maxv[k];
        else v = int'(load_val[7:4]) * 10 + int'(load_val[3:0]);
        if (v > maxv[k]) v = maxv[k];
        mval[k] = v; mpre[k] = 0;
      end else if (en) begin
        if (mpre[k] == presc[k] - 1) begin
          mpre[k] = 0;
          if (dir) begin
            if (mval[k] == maxv[k]) begin mval[k] = 0; mwrap[k] = 1'b1; end
            else mval[k] = mval[k] + 1;
          end else begin
            if (mval[k] == 0) begin mval[k] = maxv[k]; mwrap[k] = 1'b1; end
            else mval[k] = mval[k] - 1;
          end
        end else begin
          mpre[k] = mpre[k] + 1;
        end
      end
      mseg[k] = ns;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_cnt_a",  cnt_a,  bcd8(mval[0]));
    chk("model_wrap_a", wrap_a, mwrap[0]);
    chk("model_seg_a",  seg_a,  mseg[0]);
    chk("model_cnt_b",  cnt_b,  bcd8(mval[1]));
    chk("model_wrap_b", wrap_b, mwrap[1]);
    chk("model_seg_b",  seg_b,  mseg[1]);
  endtask

  task automatic cyc(input bit c, input bit l, input bit e, input bit d, input logic [7:0] lv);
    clr = c; load = l; en = e; dir = d; load_val = lv;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    bit         c, l, e, d;
    logic [7:0] lv;
    logic [7:0] exp_cnt;
    bit         exp_wrap;
    logic [15:0] exp_seg;
  } vec_t;

  vec_t vecs[18];
  bit   dir_r;

  initial begin
    // {clr, load, en, dir, load_val, count, wrap, seg of previous count}
    vecs[0]  = '{1, 0, 0, 1, 8'h00, 8'h00, 0, SEG_ZERO};
    vecs[1]  = '{0, 1, 0, 1, 8'h42, 8'h42, 0, SEG_ZERO};
    vecs[2]  = '{0, 0, 0, 1, 8'h00, 8'h42, 0, 16'h99A4};
    vecs[3]  = '{0, 1, 0, 1, 8'h3A, 8'h99, 0, 16'h99A4};
    vecs[4]  = '{0, 1, 0, 1, 8'hA5, 8'h99, 0, 16'h9090};
    vecs[5]  = '{0, 0, 1, 1, 8'h00, 8'h00, 1, 16'h9090};
    vecs[6]  = '{0, 0, 1, 0, 8'h00, 8'h99, 1, SEG_ZERO};
    vecs[7]  = '{0, 0, 1, 0, 8'h00, 8'h98, 0, 16'h9090};
    vecs[8]  = '{1, 1, 1, 1, 8'h42, 8'h00, 0, 16'h9080};
    vecs[9]  = '{0, 1, 1, 1, 8'h42, 8'h42, 0, SEG_ZERO};
    vecs[10] = '{0, 0, 1, 1, 8'h00, 8'h43, 0, 16'h99A4};
    vecs[11] = '{0, 0, 1, 0, 8'h00, 8'h42, 0, 16'h99B0};
    vecs[12] = '{0, 1, 0, 0, 8'h05, 8'h05, 0, 16'h99A4};
    vecs[13] = '{0, 0, 0, 0, 8'h00, 8'h05, 0, {LZ, 8'h92}};
    vecs[14] = '{0, 0, 1, 1, 8'h00, 8'h06, 0, {LZ, 8'h92}};
    vecs[15] = '{0, 1, 0, 1, 8'h09, 8'h09, 0, {LZ, 8'h82}};
    vecs[16] = '{0, 0, 1, 1, 8'h00, 8'h10, 0, {LZ, 8'h90}};
    vecs[17] = '{0, 0, 1, 0, 8'h00, 8'h09, 0, 16'hF9C0};

    rst_n = 1'b0; en = 1'b0; dir = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnt_a",  cnt_a,  8'h00);
    chk("rst_wrap_a", wrap_a, 1'b0);
    chk("rst_seg_a",  seg_a,  SEG_ZERO);
    chk("rst_seg_b",  seg_b,  SEG_ZERO);
    model_reset();
    rst_n = 1'b1;

    // Table-driven directed vectors
    cyc(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].d, vecs[i].lv);
      chk("vec_cnt",  cnt_a,  vecs[i].exp_cnt);
      chk("vec_wrap", wrap_a, vecs[i].exp_wrap);
      chk("vec_seg",  seg_a,  vecs[i].exp_seg);
      $display("vec %0d: clr=%0b load=%0b en=%0b dir=%0b lv=%h -> cnt=%h wrap=%0b seg=%h",
               i, vecs[i].c, vecs[i].l, vecs[i].e, vecs[i].d, vecs[i].lv, cnt_a, wrap_a, seg_a);
    end

    // Full up-count sweep and wrap
    cyc(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 99; i++) cyc(0, 0, 1, 1, 8'h00);
    chk("sweep_cnt99", cnt_a, 8'h99);
    cyc(0, 0, 0, 1, 8'h00);
    chk("sweep_seg99", seg_a, 16'h9090);
    cyc(0, 0, 1, 1, 8'h00);
    chk("sweep_wrap_cnt", cnt_a, 8'h00);
    chk("sweep_wrap_pulse", wrap_a, 1'b1);
    cyc(0, 0, 0, 1, 8'h00);
    chk("sweep_wrap_clear", wrap_a, 1'b0);
    chk("sweep_seg00", seg_a, SEG_ZERO);
    $display("sweep: 00..99 and wrap done, cnt=%h seg=%h", cnt_a, seg_a);

    // Prescaler hold on the PRESCALE=4 instance
    cyc(1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 8'h00);
    chk("pre_8cyc", cnt_b, 8'h02);
    cyc(0, 0, 1, 1, 8'h00);
    cyc(0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'h00);
    chk("pre_hold", cnt_b, 8'h02);
    cyc(0, 0, 1, 1, 8'h00);
    chk("pre_not_yet", cnt_b, 8'h02);
    cyc(0, 0, 1, 1, 8'h00);
    chk("pre_resume", cnt_b, 8'h03);
    cyc(0, 1, 0, 1, 8'h05);
    cyc(0, 0, 0, 1, 8'h00);
    chk("pre_seg05", seg_b, {LZ, 8'h92});
    $display("prescale: cnt_b=%h seg_b=%h", cnt_b, seg_b);

    // Asynchronous reset in the middle of a cycle while counting
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 8'h00);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt_a",  cnt_a,  8'h00);
    chk("arst_wrap_a", wrap_a, 1'b0);
    chk("arst_seg_a",  seg_a,  SEG_ZERO);
    chk("arst_cnt_b",  cnt_b,  8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_cnt_a", cnt_a, 8'h00);
    rst_n = 1'b1;
    cyc(0, 0, 1, 1, 8'h00);
    chk("arst_resume_a", cnt_a, 8'h01);
    $display("async reset: resumed cnt_a=%h", cnt_a);

    // Randomized stimulus against the model
    dir_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] lv;
      if ($urandom % 16 == 0) dir_r = ~dir_r;
      if ($urandom % 4 == 0) lv = 8'($urandom % 256);
      else                   lv = bcd8(int'($urandom % 100));
      cyc(($urandom % 40) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0, dir_r, lv);
    end
    $display("random: 4000 cycles applied, cnt_a=%h cnt_b=%h", cnt_a, cnt_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
